// File: rtl/gray_counter_pkg.sv
// Shared Gray-code helpers for the gray_counter slice.
// Functions work on GRAY_MAX_WIDTH bits; callers zero-extend their operands and slice the results.
package gray_pkg;

  localparam int unsigned GRAY_MAX_WIDTH = 32;

  function automatic logic [GRAY_MAX_WIDTH-1:0] bin2gray(input logic [GRAY_MAX_WIDTH-1:0] value);
    return value ^ (value >> 1);
  endfunction

  // Prefix XOR built from doubling shifts: bit i ends up as the XOR of all bits at or above i.
  function automatic logic [GRAY_MAX_WIDTH-1:0] gray2bin(input logic [GRAY_MAX_WIDTH-1:0] value);
    logic [GRAY_MAX_WIDTH-1:0] b;
    b = value;
    for (int s = 1; s < GRAY_MAX_WIDTH; s = s * 2) begin
      b = b ^ (b >> s);
    end
    return b;
  endfunction

endpackage

// File: rtl/gray_counter_if.sv
// Control and status bundle for gray_counter.
// The master drives the count controls; the slave (the counter) returns the counts and flags.
interface gray_counter_if #(
  parameter int unsigned WIDTH = 4
);
  logic             en;
  logic             up_dn;
  logic             load;
  logic [WIDTH-1:0] load_gray;
  logic [WIDTH-1:0] gray_q;
  logic [WIDTH-1:0] bin_q;
  logic             tc;
  logic             wrap;

  modport master (
    output en, up_dn, load, load_gray,
    input  gray_q, bin_q, tc, wrap
  );

  modport slave (
    input  en, up_dn, load, load_gray,
    output gray_q, bin_q, tc, wrap
  );
endinterface

// File: rtl/gray_counter_gray_to_bin_conv.sv
// Combinational Gray-to-binary decoder.
// Each binary bit is the XOR of its own Gray bit and every Gray bit above it.
module gray_to_bin_conv #(
  parameter int unsigned WIDTH = 4
) (
  input  logic [WIDTH-1:0] gray_i,
  output logic [WIDTH-1:0] bin_o
);

  for (genvar i = 0; i < WIDTH; i++) begin : g_bit
    assign bin_o[i] = ^gray_i[WIDTH-1:i];
  end

endmodule

// File: rtl/gray_counter.sv
// Registered up/down Gray-code counter with synchronous load, wrap pulse and terminal-count flag.
// Define GRAY_COUNTER_SAT_EN to saturate at the end values instead of wrapping around.
module gray_counter
  import gray_pkg::*;
#(
  parameter int unsigned WIDTH    = 4,
  parameter int unsigned INIT_BIN = 0
) (
  input logic           clk,
  input logic           rst,
  gray_counter_if.slave bus
);

  localparam logic [WIDTH-1:0] MAX_VAL = '1;
  localparam logic [WIDTH-1:0] INIT_B  = WIDTH'(INIT_BIN);
  localparam logic [WIDTH-1:0] INIT_G  = WIDTH'(bin2gray(INIT_BIN));

  logic [WIDTH-1:0] load_bin;
  logic [WIDTH-1:0] step_bin;
  logic [WIDTH-1:0] bin_d, bin_q;
  logic [WIDTH-1:0] gray_d, gray_q;
  logic             wrap_d, wrap_q;
  logic             at_end;

  gray_to_bin_conv #(
    .WIDTH (WIDTH)
  ) u_load_dec (
    .gray_i (bus.load_gray),
    .bin_o  (load_bin)
  );

  assign at_end   = bus.up_dn ? (bin_q == MAX_VAL) : (bin_q == '0);
  assign step_bin = bus.up_dn ? (bin_q + WIDTH'(1)) : (bin_q - WIDTH'(1));

  always_comb begin
    bin_d  = bin_q;
    wrap_d = 1'b0;
    if (bus.load) begin
      bin_d = load_bin;
    end else if (bus.en) begin
`ifdef GRAY_COUNTER_SAT_EN
      if (!at_end) begin
        bin_d = step_bin;
      end
`else
      bin_d  = step_bin;
      wrap_d = at_end;
`endif
    end
  end

  // Gray is always re-encoded from the next binary value so the output is a clean register.
  always_comb begin
    gray_d = WIDTH'(bin2gray(GRAY_MAX_WIDTH'(bin_d)));
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bin_q  <= INIT_B;
      gray_q <= INIT_G;
      wrap_q <= 1'b0;
    end else begin
      bin_q  <= bin_d;
      gray_q <= gray_d;
      wrap_q <= wrap_d;
    end
  end

  assign bus.bin_q  = bin_q;
  assign bus.gray_q = gray_q;
  assign bus.wrap   = wrap_q;
  assign bus.tc     = at_end;

endmodule

// File: tb/tb_gray_counter.sv
// Self-checking bench for gray_counter (WIDTH=4, INIT_BIN=0): directed table, corner sequences, random run.
// Expectations follow GRAY_COUNTER_SAT_EN when the macro is defined for the build.
module tb_gray_counter;

  localparam int W    = 4;
  localparam int MAXV = (1 << W) - 1;

  logic clk;
  logic rst;

  gray_counter_if #(.WIDTH(W)) bus ();

  gray_counter #(
    .WIDTH    (W),
    .INIT_BIN (0)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  int m_bin  = 0;
  bit m_wrap = 1'b0;

  typedef struct {
    bit       en;
    bit       up;
    bit       ld;
    bit [3:0] lg;
    int       e_bin;
    bit [3:0] e_gray;
    bit       e_wrap;
  } vec_t;

  vec_t tbl [10];

  function automatic int to_gray(input int v);
    return v ^ (v >> 1);
  endfunction

  function automatic int from_gray(input int g);
    int r;
    r = 0;
    for (int v = 0; v <= MAXV; v++) begin
      if (to_gray(v) == g) r = v;
    end
    return r;
  endfunction

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_step(input bit e, input bit u, input bit l, input bit [3:0] g);
    m_wrap = 1'b0;
    if (l) begin
      m_bin = from_gray(int'(g));
    end else if (e) begin
      if (u) begin
        if (m_bin == MAXV) begin
`ifndef GRAY_COUNTER_SAT_EN
          m_bin  = 0;
          m_wrap = 1'b1;
`endif
        end else begin
          m_bin = m_bin + 1;
        end
      end else begin
        if (m_bin == 0) begin
`ifndef GRAY_COUNTER_SAT_EN
          m_bin  = MAXV;
          m_wrap = 1'b1;
`endif
        end else begin
          m_bin = m_bin - 1;
        end
      end
    end
  endtask

  task automatic compare_model(input string tag);
    int exp_tc;
    exp_tc = bus.up_dn ? int'(m_bin == MAXV) : int'(m_bin == 0);
    check({tag, ".bin"},  int'(bus.bin_q),  m_bin);
    check({tag, ".gray"}, int'(bus.gray_q), to_gray(m_bin));
    check({tag, ".wrap"}, int'(bus.wrap),   int'(m_wrap));
    check({tag, ".tc"},   int'(bus.tc),     exp_tc);
  endtask

  task automatic chk_const(input string tag, input int b, input int g, input int w);
    check({tag, ".cbin"},  int'(bus.bin_q),  b);
    check({tag, ".cgray"}, int'(bus.gray_q), g);
    check({tag, ".cwrap"}, int'(bus.wrap),   w);
  endtask

  task automatic step(input string tag, input bit e, input bit u, input bit l, input bit [3:0] g);
    bus.en        = e;
    bus.up_dn     = u;
    bus.load      = l;
    bus.load_gray = g;
    @(posedge clk);
    #1;
    model_step(e, u, l, g);
    compare_model(tag);
  endtask

  task automatic do_reset();
    bus.en   = 1'b0;
    bus.load = 1'b0;
    rst      = 1'b1;
    #3;
    rst      = 1'b0;
    m_bin    = 0;
    m_wrap   = 1'b0;
  endtask

  initial begin
    bit [3:0] prev_gray;
    bit       e, u, l;
    bit [3:0] g;

    rst           = 1'b1;
    bus.en        = 1'b0;
    bus.up_dn     = 1'b1;
    bus.load      = 1'b0;
    bus.load_gray = '0;

    tbl[0] = '{1, 1, 0, 4'h0,  1, 4'b0001, 0};
    tbl[1] = '{1, 1, 0, 4'h0,  2, 4'b0011, 0};
    tbl[2] = '{1, 1, 0, 4'h0,  3, 4'b0010, 0};
    tbl[3] = '{1, 1, 0, 4'h0,  4, 4'b0110, 0};
    tbl[4] = '{1, 1, 0, 4'h0,  5, 4'b0111, 0};
    tbl[5] = '{1, 1, 1, 4'hA, 12, 4'b1010, 0};
    tbl[6] = '{1, 1, 0, 4'h0, 13, 4'b1011, 0};
    tbl[7] = '{1, 1, 0, 4'h0, 14, 4'b1001, 0};
    tbl[8] = '{1, 1, 0, 4'h0, 15, 4'b1000, 0};
    tbl[9] = '{0, 1, 0, 4'h0, 15, 4'b1000, 0};

    @(negedge clk);
    #1;
    check("reset.bin",  int'(bus.bin_q),  0);
    check("reset.gray", int'(bus.gray_q), 0);
    check("reset.wrap", int'(bus.wrap),   0);
    check("reset.tc_up", int'(bus.tc),    0);
    rst = 1'b0;
    @(posedge clk);
    #1;

    for (int i = 0; i < 10; i++) begin
      step($sformatf("tbl%0d", i), tbl[i].en, tbl[i].up, tbl[i].ld, tbl[i].lg);
      chk_const($sformatf("tbl%0d", i), tbl[i].e_bin, int'(tbl[i].e_gray), int'(tbl[i].e_wrap));
    end
    check("tbl.tc_at_max", int'(bus.tc), 1);

    // Up across the top: wrap pulses once, then clears.
    step("wrap_up0", 1, 1, 0, 4'h0);
`ifdef GRAY_COUNTER_SAT_EN
    chk_const("wrap_up0", 15, 4'b1000, 0);
    check("sat_up.tc", int'(bus.tc), 1);
`else
    chk_const("wrap_up0", 0, 4'b0000, 1);
`endif
    step("wrap_up1", 1, 1, 0, 4'h0);
`ifdef GRAY_COUNTER_SAT_EN
    chk_const("wrap_up1", 15, 4'b1000, 0);
    step("wrap_up2", 1, 1, 0, 4'h0);
    chk_const("wrap_up2", 15, 4'b1000, 0);
`else
    chk_const("wrap_up1", 1, 4'b0001, 0);
`endif

    // Down from reset.
    @(negedge clk);
    do_reset();
    @(posedge clk);
    #1;
    step("wrap_dn0", 1, 0, 0, 4'h0);
`ifdef GRAY_COUNTER_SAT_EN
    chk_const("wrap_dn0", 0, 4'b0000, 0);
    check("sat_dn.tc", int'(bus.tc), 1);
`else
    chk_const("wrap_dn0", 15, 4'b1000, 1);
`endif
    step("wrap_dn1", 1, 0, 0, 4'h0);
`ifdef GRAY_COUNTER_SAT_EN
    chk_const("wrap_dn1", 0, 4'b0000, 0);
`else
    chk_const("wrap_dn1", 14, 4'b1001, 0);
`endif

    // Async reset between edges at bin 7.
    step("pre_rst_load", 0, 1, 1, 4'b0100);
    chk_const("pre_rst_load", 7, 4'b0100, 0);
    bus.en    = 1'b1;
    bus.up_dn = 1'b1;
    #2;
    rst = 1'b1;
    #1;
    chk_const("async_rst", 0, 0, 0);
    #1;
    rst    = 1'b0;
    m_bin  = 0;
    m_wrap = 1'b0;
    step("post_rst0", 1, 1, 0, 4'h0);
    chk_const("post_rst0", 1, 4'b0001, 0);
    step("post_rst1", 1, 1, 0, 4'h0);
    chk_const("post_rst1", 2, 4'b0011, 0);

    // Random run against the model, with a single-bit Gray change check on plain steps.
    for (int n = 0; n < 400; n++) begin
      prev_gray = bus.gray_q;
      e = ($urandom_range(0, 3) != 0);
      u = $urandom_range(0, 1) != 0;
      l = ($urandom_range(0, 15) == 0);
      g = 4'($urandom_range(0, MAXV));
      step("rand", e, u, l, g);
      if (!l && e && (bus.gray_q != prev_gray)) begin
        check("rand.gray_1bit", $countones(bus.gray_q ^ prev_gray), 1);
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
